// File: rtl/ysyx_040750_mem_stage.sv
// Memory-access stage: accepts one instruction from EX/MEM, runs the data-memory
// req/gnt/rvalid transaction for loads/stores, and hands the bundle to MEM/WB.
// Optional: YSYX_040750_MEM_MISALIGN_CHK_EN adds misaligned-access suppression and O_misalign.
module ysyx_040750_mem_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              I_sys_clk,
    input  logic              I_rst_n,
    input  logic              I_EX_MEM_valid,
    output logic              O_MEM_allowin,
    input  logic [31:0]       I_pc,
    input  logic [XLEN-1:0]   I_alu_out,
    input  logic [XLEN-1:0]   I_store_data,
    input  logic              I_mem_ren,
    input  logic              I_mem_wen,
    input  logic [7:0]        I_mem_wstrb,
    input  logic              I_reg_wen,
    input  logic [4:0]        I_rd_addr,
    input  logic [1:0]        I_regin_sel,
    output logic              O_dmem_req,
    output logic              O_dmem_we,
    output logic [ADDR_W-1:0] O_dmem_addr,
    output logic [XLEN-1:0]   O_dmem_wdata,
    output logic [7:0]        O_dmem_wstrb,
    input  logic              I_dmem_gnt,
    input  logic              I_dmem_rvalid,
    input  logic [XLEN-1:0]   I_dmem_rdata,
    output logic              O_MEM_WB_valid,
    input  logic              I_MEM_WB_allowin,
    output logic [31:0]       O_pc,
    output logic [XLEN-1:0]   O_alu_out,
    output logic              O_reg_wen,
    output logic [4:0]        O_rd_addr,
    output logic [1:0]        O_regin_sel,
    output logic [XLEN-1:0]   O_mem_data,
    output logic [2:0]        O_mem_shamt
`ifdef YSYX_040750_MEM_MISALIGN_CHK_EN
    ,
    output logic              O_misalign
`endif
);

    localparam int unsigned OFS_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state;
    logic   is_load;
    logic   accept;
    logic   mem_op;
    logic   misalign;

    assign O_MEM_allowin = (state == S_IDLE) || ((state == S_DONE) && I_MEM_WB_allowin);
    assign accept        = I_EX_MEM_valid && O_MEM_allowin;
    assign mem_op        = I_mem_ren || I_mem_wen;

`ifdef YSYX_040750_MEM_MISALIGN_CHK_EN
    logic [3:0] span_bytes;

    // Access span: strobe popcount for stores, 1<<size (regin_sel) for loads.
    always_comb begin
        span_bytes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            span_bytes = span_bytes + 4'(I_mem_wstrb[i]);
        end
        if (I_mem_ren) begin
            span_bytes = 4'd1 << I_regin_sel;
        end
        misalign = mem_op && ((I_alu_out[OFS_W-1:0] & OFS_W'(span_bytes - 4'd1)) != 3'd0);
    end
`else
    assign misalign = 1'b0;
`endif

    // Single-process FSM with all bundle and memory-port outputs registered.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state          <= S_IDLE;
            is_load        <= 1'b0;
            O_dmem_req     <= 1'b0;
            O_dmem_we      <= 1'b0;
            O_dmem_addr    <= '0;
            O_dmem_wdata   <= '0;
            O_dmem_wstrb   <= '0;
            O_MEM_WB_valid <= 1'b0;
            O_pc           <= '0;
            O_alu_out      <= '0;
            O_reg_wen      <= 1'b0;
            O_rd_addr      <= '0;
            O_regin_sel    <= '0;
            O_mem_data     <= '0;
            O_mem_shamt    <= '0;
`ifdef YSYX_040750_MEM_MISALIGN_CHK_EN
            O_misalign     <= 1'b0;
`endif
        end else if (accept) begin
            O_pc         <= I_pc;
            O_alu_out    <= I_alu_out;
            O_reg_wen    <= I_reg_wen && !misalign;
            O_rd_addr    <= I_rd_addr;
            O_regin_sel  <= I_regin_sel;
            O_mem_shamt  <= I_alu_out[OFS_W-1:0];
            O_dmem_addr  <= {I_alu_out[ADDR_W-1:OFS_W], 3'b000};
            O_dmem_wdata <= I_store_data;
            O_dmem_wstrb <= I_mem_wstrb;
            is_load      <= I_mem_ren;
`ifdef YSYX_040750_MEM_MISALIGN_CHK_EN
            O_misalign   <= misalign;
`endif
            if (mem_op && !misalign) begin
                state          <= S_REQ;
                O_dmem_req     <= 1'b1;
                O_dmem_we      <= !I_mem_ren;
                O_MEM_WB_valid <= 1'b0;
            end else begin
                state          <= S_DONE;
                O_dmem_req     <= 1'b0;
                O_dmem_we      <= 1'b0;
                O_MEM_WB_valid <= 1'b1;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (I_dmem_gnt) begin
                        O_dmem_req <= 1'b0;
                        O_dmem_we  <= 1'b0;
                        if (!is_load) begin
                            state          <= S_DONE;
                            O_MEM_WB_valid <= 1'b1;
                        end else if (I_dmem_rvalid) begin
                            O_mem_data     <= I_dmem_rdata;
                            state          <= S_DONE;
                            O_MEM_WB_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (I_dmem_rvalid) begin
                        O_mem_data     <= I_dmem_rdata;
                        state          <= S_DONE;
                        O_MEM_WB_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (I_MEM_WB_allowin) begin
                        state          <= S_IDLE;
                        O_MEM_WB_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
